// File: rtl/t_ff.sv
// -----------------------------------------------------------------------------
// t_ff : registered toggle flip-flop bank
//
// Purpose
//   WIDTH independent toggle flops. On every rising clk edge each bit of q
//   inverts when its t bit is 1 and holds when its t bit is 0. A synchronous,
//   active-high reset loads RESET_VAL and takes priority over t. Bits are
//   independent; there is no carry between them.
//
// Parameters
//   WIDTH      number of toggle bits (>= 1)
//   RESET_VAL  value loaded into q on reset (sized to WIDTH bits)
//
// Ports
//   clk  in   1      rising-edge clock, sole clock
//   rst  in   1      synchronous reset, active-high
//   t    in   WIDTH  per-bit toggle enable, sampled on rising clk
//   q    out  WIDTH  registered state, driven straight from the flops
//   qn   out  WIDTH  ~q, only present when T_FF_QN_EN is defined
//
// Build option
//   T_FF_QN_EN : when defined, adds the complementary output qn.
//                When undefined, qn does not exist.
// -----------------------------------------------------------------------------
module t_ff #(
   parameter int                WIDTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
`ifdef T_FF_QN_EN
   ,
   output logic [WIDTH-1:0] qn
`endif
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next state: bitwise toggle of the bits whose enable is set.
   always_comb begin
      q_d = q_q;
      if (rst == 1'b0) begin
         q_d = q_q ^ t;
      end else begin
         q_d = RESET_VAL;
      end
   end

   // State register; reset is sampled on the clock edge only.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   // q comes straight from the flops, so t and rst cannot reach it
   // combinationally.
   assign q = q_q;

`ifdef T_FF_QN_EN
   // Complement is derived from the flop outputs, so it follows q exactly,
   // including reading ~RESET_VAL while in reset.
   assign qn = ~q_q;
`else
   // Single-rail build: no complementary output.
`endif

endmodule

// File: tb/tb_t_ff.sv
// -----------------------------------------------------------------------------
// tb_t_ff : scoreboard bench for t_ff
//
// Two instances are exercised in lock-step from one directed vector table:
//   u_dut1 : WIDTH=1, RESET_VAL=0
//   u_dut4 : WIDTH=4, RESET_VAL=4'b1010
// The driver applies each vector on the falling edge and pushes the
// hand-computed post-edge values into a queue. An independent monitor pops
// one entry after every rising edge and checks q (and qn when built with
// T_FF_QN_EN) just after the edge and again mid-cycle, while the driver is
// deliberately glitching t, to show q only changes on clock edges.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_t_ff;

   typedef struct {
      string      name;
      logic       exp1;
      logic [3:0] exp4;
   } exp_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       t1;
      logic       exp1;
      logic [3:0] t4;
      logic [3:0] exp4;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       t1;
   logic [3:0] t4;
   logic       q1;
   logic [3:0] q4;
`ifdef T_FF_QN_EN
   logic       qn1;
   logic [3:0] qn4;
`endif

   int checks   = 0;
   int failures = 0;
   exp_t sb_q[$];
   vec_t vecs[$];

   t_ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .t   (t1),
      .q   (q1)
`ifdef T_FF_QN_EN
      ,
      .qn  (qn1)
`endif
   );

   t_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .t   (t4),
      .q   (q4)
`ifdef T_FF_QN_EN
      ,
      .qn  (qn4)
`endif
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_outputs(input exp_t e, input string phase);
      checks = checks + 1;
      if (q1 !== e.exp1) begin
         failures = failures + 1;
         $display("FAIL %s/%s q1: got %b expected %b", e.name, phase, q1, e.exp1);
      end
      checks = checks + 1;
      if (q4 !== e.exp4) begin
         failures = failures + 1;
         $display("FAIL %s/%s q4: got %b expected %b", e.name, phase, q4, e.exp4);
      end
`ifdef T_FF_QN_EN
      checks = checks + 1;
      if (qn1 !== ~e.exp1) begin
         failures = failures + 1;
         $display("FAIL %s/%s qn1: got %b expected %b", e.name, phase, qn1, ~e.exp1);
      end
      checks = checks + 1;
      if (qn4 !== ~e.exp4) begin
         failures = failures + 1;
         $display("FAIL %s/%s qn4: got %b expected %b", e.name, phase, qn4, ~e.exp4);
      end
`endif
   endtask

   // Monitor: one expected entry per rising edge once stimulus has started.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_outputs(e, "edge");
            #5;  // mid-cycle, inside the driver's t glitch window
            check_outputs(e, "mid");
         end
      end
   end

   function automatic vec_t mk(input string n, input logic r, input logic a, input logic ea,
                               input logic [3:0] b, input logic [3:0] eb);
      vec_t v;
      v.name = n; v.rst = r; v.t1 = a; v.exp1 = ea; v.t4 = b; v.exp4 = eb;
      return v;
   endfunction

   // Driver: vector table with hand-computed post-edge values.
   initial begin
      exp_t e;
      rst = 1'b1;
      t1  = 1'b0;
      t4  = 4'b0000;

      //             name          rst   t1    q1    t4       q4
      vecs.push_back(mk("rst_t0",    1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010));
      vecs.push_back(mk("rst_t1",    1'b1, 1'b1, 1'b0, 4'b1111, 4'b1010));
      vecs.push_back(mk("hold0_a",   1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010));
      vecs.push_back(mk("hold0_b",   1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010));
      vecs.push_back(mk("tog_1",     1'b0, 1'b1, 1'b1, 4'b0110, 4'b1100));
      vecs.push_back(mk("tog_2",     1'b0, 1'b1, 1'b0, 4'b0110, 4'b1010));
      vecs.push_back(mk("tog_3",     1'b0, 1'b1, 1'b1, 4'b0110, 4'b1100));
      vecs.push_back(mk("tog_4",     1'b0, 1'b1, 1'b0, 4'b0110, 4'b1010));
      vecs.push_back(mk("tog_5",     1'b0, 1'b1, 1'b1, 4'b0110, 4'b1100));
      vecs.push_back(mk("hold1_a",   1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100));
      vecs.push_back(mk("hold1_b",   1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100));
      vecs.push_back(mk("hold1_c",   1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100));
      vecs.push_back(mk("mid_rst",   1'b1, 1'b1, 1'b0, 4'b0110, 4'b1010));
      vecs.push_back(mk("restart_1", 1'b0, 1'b1, 1'b1, 4'b0110, 4'b1100));
      vecs.push_back(mk("restart_2", 1'b0, 1'b1, 1'b0, 4'b0110, 4'b1010));
      vecs.push_back(mk("long_rst1", 1'b1, 1'b1, 1'b0, 4'b0110, 4'b1010));
      vecs.push_back(mk("long_rst2", 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1010));
      vecs.push_back(mk("indep_1",   1'b0, 1'b1, 1'b1, 4'b0001, 4'b1011));
      vecs.push_back(mk("indep_2",   1'b0, 1'b0, 1'b1, 4'b1001, 4'b0010));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         // Glitch t to the opposite value for 2 ns; only the settled value
         // present at the rising edge may matter.
         rst = vecs[i].rst;
         t1  = ~vecs[i].t1;
         t4  = ~vecs[i].t4;
         e.name = vecs[i].name;
         e.exp1 = vecs[i].exp1;
         e.exp4 = vecs[i].exp4;
         sb_q.push_back(e);
         #2;
         t1 = vecs[i].t1;
         t4 = vecs[i].t4;
      end

      // Let the monitor drain the last entry (edge + mid-cycle checks).
      @(negedge clk);
      t1 = 1'b0;
      t4 = 4'b0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks = checks + 1;
      if (sb_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
